// File: rtl/ladybird_config.sv
// rtl/ladybird_config.sv - shared constants and types for the ladybird bus blocks
package ladybird_config;

  localparam int XLEN            = 32;
  localparam int RAM_LATENCY_MAX = 15;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } bus_resp_state_t;

endpackage

// File: rtl/ladybird_bram.sv
// rtl/ladybird_bram.sv - single-port byte-writable storage with registered read-before-write
module ladybird_bram
  import ladybird_config::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  anrst,
  input  logic                  nrst,
  input  logic                  en,
  input  logic [XLEN/8-1:0]     we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [XLEN-1:0]       wdata,
  output logic [XLEN-1:0]       rdata
);

  logic [XLEN-1:0] mem [2**DEPTH_LOG2];
  logic [XLEN-1:0] rdata_d, rdata_q;

  always_comb begin
    rdata_d = rdata_q;
    if (en) rdata_d = mem[addr];
  end

  // Only the output register is reset; the array keeps its contents.
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst)     rdata_q <= '0;
    else if (!nrst) rdata_q <= '0;
    else            rdata_q <= rdata_d;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < XLEN/8; i++) begin
      if (en && we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ladybird_ram_responder.sv
// rtl/ladybird_ram_responder.sv - request/grant bus responder in front of an on-chip RAM
module ladybird_ram_responder
  import ladybird_config::*;
#(
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 1
) (
  input  logic              clk,
  input  logic              anrst,
  input  logic              nrst,
  input  logic              req,
  output logic              gnt,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN/8-1:0] wstrb,
  inout  wire  [XLEN-1:0]   data,
  output logic              data_gnt
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  if (LATENCY < 1 || LATENCY > RAM_LATENCY_MAX) begin : g_bad_latency
    $error("ladybird_ram_responder: LATENCY out of range");
  end

  bus_resp_state_t  state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             data_gnt_d, data_gnt_q;
  logic [XLEN-1:0]  resp;
  logic             unused_addr_bits;

  // Zero-cycle grant; the resets gate it so nothing is accepted while held.
  assign gnt              = req && (state_q == IDLE) && anrst && nrst;
  assign unused_addr_bits = ^{addr[XLEN-1:DEPTH_LOG2+2], addr[1:0]};

  ladybird_bram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_bram (
    .clk  (clk),
    .anrst(anrst),
    .nrst (nrst),
    .en   (gnt),
    .we   (wstrb),
    .addr (addr[DEPTH_LOG2+1:2]),
    .wdata(data),
    .rdata(resp)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (gnt) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    data_gnt_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_gnt_q <= 1'b0;
    end else if (!nrst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_gnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_gnt_q <= data_gnt_d;
    end
  end

  assign data_gnt = data_gnt_q;
  assign data     = data_gnt_q ? resp : 'z;

endmodule

// File: tb/tb_ladybird_ram_responder.sv
// tb/tb_ladybird_ram_responder.sv - directed bench for the ladybird RAM responder
module tb_ladybird_ram_responder;

  logic        clk = 1'b0;
  logic        anrst = 1'b0;
  logic        nrst = 1'b1;
  int          n_cmp = 0;
  int          n_err = 0;

  logic        req1 = 1'b0, gnt1, dgnt1, en1 = 1'b0;
  logic [31:0] addr1 = '0, drv1 = '0;
  logic [3:0]  wstrb1 = '0;
  wire  [31:0] bus1;
  logic        req3 = 1'b0, gnt3, dgnt3, en3 = 1'b0;
  logic [31:0] addr3 = '0, drv3 = '0;
  logic [3:0]  wstrb3 = '0;
  wire  [31:0] bus3;

  always #5 clk = ~clk;

  assign bus1 = en1 ? drv1 : 'z;
  assign bus3 = en3 ? drv3 : 'z;
  pullup pu1 (bus1);
  pullup pu3 (bus3);

  ladybird_ram_responder #(.DEPTH_LOG2(4), .LATENCY(1)) u_lat1 (
    .clk(clk), .anrst(anrst), .nrst(nrst), .req(req1), .gnt(gnt1),
    .addr(addr1), .wstrb(wstrb1), .data(bus1), .data_gnt(dgnt1)
  );

  ladybird_ram_responder #(.DEPTH_LOG2(12), .LATENCY(3)) u_lat3 (
    .clk(clk), .anrst(anrst), .nrst(nrst), .req(req3), .gnt(gnt3),
    .addr(addr3), .wstrb(wstrb3), .data(bus3), .data_gnt(dgnt3)
  );

  task automatic drive1(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    req1 = 1'b1; addr1 = a; wstrb1 = s; drv1 = d; en1 = (s != 4'h0);
  endtask

  task automatic release1();
    req1 = 1'b0; wstrb1 = 4'h0; en1 = 1'b0;
  endtask

  task automatic drive3(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    req3 = 1'b1; addr3 = a; wstrb3 = s; drv3 = d; en3 = (s != 4'h0);
  endtask

  task automatic release3();
    req3 = 1'b0; wstrb3 = 4'h0; en3 = 1'b0;
  endtask

  task automatic write1(input logic [31:0] a, input logic [31:0] d);
    drive1(a, 4'hF, d);
    @(posedge clk); #1;
    release1();
    @(posedge clk); #1;
  endtask

  task automatic write3(input logic [31:0] a, input logic [31:0] d);
    drive3(a, 4'hF, d);
    @(posedge clk); #1;
    release3();
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    req1 = 1'b1; req3 = 1'b1;
    #2;
    n_cmp++; if (gnt1 !== 1'b0) begin n_err++; $display("FAIL rst_gnt1: got %b want 0", gnt1); end
    n_cmp++; if (gnt3 !== 1'b0) begin n_err++; $display("FAIL rst_gnt3: got %b want 0", gnt3); end
    n_cmp++; if (dgnt1 !== 1'b0) begin n_err++; $display("FAIL rst_dgnt1: got %b want 0", dgnt1); end
    n_cmp++; if (bus1 !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rst_bus1_released: got %h want ffffffff", bus1); end
    @(posedge clk); #1;
    n_cmp++; if (gnt1 !== 1'b0) begin n_err++; $display("FAIL rst_gnt1_after_edge: got %b want 0", gnt1); end
    req1 = 1'b0; req3 = 1'b0;
    anrst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_read();
    write1(32'h10, 32'hDEAD_BEEF);
    drive1(32'h10, 4'h0, 32'h0);
    @(negedge clk);
    n_cmp++; if (gnt1 !== 1'b1) begin n_err++; $display("FAIL read_gnt: got %b want 1", gnt1); end
    @(posedge clk); #1;
    release1();
    @(negedge clk);
    n_cmp++; if (dgnt1 !== 1'b1) begin n_err++; $display("FAIL read_dgnt: got %b want 1", dgnt1); end
    n_cmp++; if (bus1 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL read_data: got %h want deadbeef", bus1); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (dgnt1 !== 1'b0) begin n_err++; $display("FAIL read_dgnt_drop: got %b want 0", dgnt1); end
    n_cmp++; if (bus1 !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL read_bus_released: got %h want ffffffff", bus1); end
    @(posedge clk); #1;
  endtask

  task automatic test_byte_write();
    write1(32'h0, 32'h1122_3344);
    drive1(32'h0, 4'b0101, 32'hAABB_CCDD);
    @(negedge clk);
    n_cmp++; if (gnt1 !== 1'b1) begin n_err++; $display("FAIL bw_gnt: got %b want 1", gnt1); end
    @(posedge clk); #1;
    release1();
    @(negedge clk);
    n_cmp++; if (dgnt1 !== 1'b1) begin n_err++; $display("FAIL bw_ack: got %b want 1", dgnt1); end
    n_cmp++; if (bus1 !== 32'h1122_3344) begin n_err++; $display("FAIL bw_old_word: got %h want 11223344", bus1); end
    @(posedge clk); #1;
    drive1(32'h0, 4'h0, 32'h0);
    @(posedge clk); #1;
    release1();
    @(negedge clk);
    n_cmp++; if (bus1 !== 32'h11BB_33DD) begin n_err++; $display("FAIL bw_merged: got %h want 11bb33dd", bus1); end
    @(posedge clk); #1;
  endtask

  task automatic test_alias();
    write1(32'h40, 32'h0000_0005);
    drive1(32'h0, 4'h0, 32'h0);
    @(posedge clk); #1;
    release1();
    @(negedge clk);
    n_cmp++; if (bus1 !== 32'h0000_0005) begin n_err++; $display("FAIL alias_0x0: got %h want 00000005", bus1); end
    @(posedge clk); #1;
    drive1(32'h3, 4'h0, 32'h0);
    @(posedge clk); #1;
    release1();
    @(negedge clk);
    n_cmp++; if (bus1 !== 32'h0000_0005) begin n_err++; $display("FAIL alias_0x3: got %h want 00000005", bus1); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int issued;
    int got;
    for (int i = 0; i < 8; i++) write1(32'(i * 4), 32'hC0DE_0000 | 32'(i));
    issued = 0; got = 0;
    drive1(32'h0, 4'h0, 32'h0);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (dgnt1) begin
        n_cmp++;
        if (bus1 !== (32'hC0DE_0000 | 32'(got))) begin
          n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", got, bus1, 32'hC0DE_0000 | 32'(got));
        end
        got++;
      end
      if (gnt1) issued++;
      @(posedge clk); #1;
      addr1 = 32'(issued * 4);
      if (issued == 8) req1 = 1'b0;
    end
    release1();
    n_cmp++; if (got != 8) begin n_err++; $display("FAIL b2b_pulses: got %0d want 8", got); end
  endtask

  task automatic test_latency();
    logic exp_gnt, exp_dgnt;
    write3(32'h8, 32'h0BAD_F00D);
    drive3(32'h8, 4'h0, 32'h0);
    @(negedge clk);
    n_cmp++; if (gnt3 !== 1'b1) begin n_err++; $display("FAIL lat_gnt_c0: got %b want 1", gnt3); end
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      exp_gnt  = (k == 4);
      exp_dgnt = (k == 3);
      n_cmp++; if (gnt3 !== exp_gnt) begin n_err++; $display("FAIL lat_gnt_c%0d: got %b want %b", k, gnt3, exp_gnt); end
      n_cmp++; if (dgnt3 !== exp_dgnt) begin n_err++; $display("FAIL lat_dgnt_c%0d: got %b want %b", k, dgnt3, exp_dgnt); end
      if (k == 3) begin
        n_cmp++; if (bus3 !== 32'h0BAD_F00D) begin n_err++; $display("FAIL lat_data: got %h want 0badf00d", bus3); end
      end
    end
    @(posedge clk); #1;
    release3();
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset_mid();
    int pulses;
    drive3(32'h8, 4'h0, 32'h0);
    @(negedge clk);
    n_cmp++; if (gnt3 !== 1'b1) begin n_err++; $display("FAIL rmid_accept: got %b want 1", gnt3); end
    @(posedge clk); #1;
    #2 anrst = 1'b0;
    #1;
    n_cmp++; if (gnt3 !== 1'b0) begin n_err++; $display("FAIL rmid_gnt_in_rst: got %b want 0", gnt3); end
    n_cmp++; if (dgnt3 !== 1'b0) begin n_err++; $display("FAIL rmid_dgnt_in_rst: got %b want 0", dgnt3); end
    @(posedge clk); #1;
    n_cmp++; if (gnt3 !== 1'b0) begin n_err++; $display("FAIL rmid_gnt_held: got %b want 0", gnt3); end
    release3();
    anrst = 1'b1;
    pulses = 0;
    repeat (5) begin @(negedge clk); if (dgnt3) pulses++; end
    n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL rmid_dropped: got %0d pulses want 0", pulses); end
    @(posedge clk); #1;
    drive3(32'h8, 4'h0, 32'h0);
    @(negedge clk);
    n_cmp++; if (gnt3 !== 1'b1) begin n_err++; $display("FAIL rmid_regrant: got %b want 1", gnt3); end
    @(posedge clk); #1;
    release3();
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    n_cmp++; if (bus3 !== 32'h0BAD_F00D || dgnt3 !== 1'b1) begin n_err++; $display("FAIL rmid_resp: got %b/%h want 1/0badf00d", dgnt3, bus3); end
    @(posedge clk); #1;
  endtask

  task automatic test_sync_reset();
    int pulses;
    drive3(32'h8, 4'h0, 32'h0);
    @(negedge clk);
    n_cmp++; if (gnt3 !== 1'b1) begin n_err++; $display("FAIL srst_accept: got %b want 1", gnt3); end
    @(posedge clk); #1;
    nrst = 1'b0;
    @(negedge clk);
    n_cmp++; if (gnt3 !== 1'b0) begin n_err++; $display("FAIL srst_gnt: got %b want 0", gnt3); end
    @(posedge clk); #1;
    nrst = 1'b1;
    release3();
    pulses = 0;
    repeat (5) begin @(negedge clk); if (dgnt3) pulses++; end
    n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL srst_dropped: got %0d pulses want 0", pulses); end
    @(posedge clk); #1;
    drive3(32'h8, 4'h0, 32'h0);
    @(negedge clk);
    n_cmp++; if (gnt3 !== 1'b1) begin n_err++; $display("FAIL srst_regrant: got %b want 1", gnt3); end
    @(posedge clk); #1;
    release3();
    repeat (3) begin @(posedge clk); #1; end
  endtask

  initial begin
    test_reset();
    test_read();
    test_byte_write();
    test_alias();
    test_back_to_back();
    test_latency();
    test_reset_mid();
    test_sync_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
